// File: rtl/matmul_4x4_complex_seq.sv
// 4x4 complex matrix multiply C = A*B built around a single time-multiplexed complex MAC (64 cycles per result).
// Optional macro CMAC_3MULT_EN: build the complex multiply from three real multipliers instead of four.
module matmul_4x4_complex_seq #(
  parameter int w = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic signed [w-1:0]   A_real [0:3][0:3],
  input  logic signed [w-1:0]   A_imag [0:3][0:3],
  input  logic signed [w-1:0]   B_real [0:3][0:3],
  input  logic signed [w-1:0]   B_imag [0:3][0:3],
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic signed [2*w+2:0] C_real [0:3][0:3],
  output logic signed [2*w+2:0] C_imag [0:3][0:3],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);
  localparam int AW = 2*w+3;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t               r_state, w_next;
  logic signed [w-1:0]  r_aRe [0:3][0:3];
  logic signed [w-1:0]  r_aIm [0:3][0:3];
  logic signed [w-1:0]  r_bRe [0:3][0:3];
  logic signed [w-1:0]  r_bIm [0:3][0:3];
  logic [5:0]           r_idx;
  logic signed [AW-1:0] r_accRe, r_accIm;
  logic [1:0]           w_i, w_j, w_k;
  logic signed [w-1:0]  w_a, w_b, w_c, w_d;
  logic signed [AW-1:0] w_prodRe, w_prodIm, w_sumRe, w_sumIm;
  logic                 w_accept;

  // Index layout {i,j,k}: k advances fastest, so one output element completes every 4 cycles.
  assign w_i = r_idx[5:4];
  assign w_j = r_idx[3:2];
  assign w_k = r_idx[1:0];

  assign w_a = r_aRe[w_i][w_k];
  assign w_b = r_aIm[w_i][w_k];
  assign w_c = r_bRe[w_k][w_j];
  assign w_d = r_bIm[w_k][w_j];

`ifdef CMAC_3MULT_EN
  logic signed [w:0]    w_aPb, w_dMc, w_cPd;
  logic signed [AW-1:0] w_t1, w_t2, w_t3;

  assign w_aPb = (w+1)'(w_a) + (w+1)'(w_b);
  assign w_dMc = (w+1)'(w_d) - (w+1)'(w_c);
  assign w_cPd = (w+1)'(w_c) + (w+1)'(w_d);
  assign w_t1  = AW'(w_c) * AW'(w_aPb);
  assign w_t2  = AW'(w_a) * AW'(w_dMc);
  assign w_t3  = AW'(w_b) * AW'(w_cPd);
  assign w_prodRe = w_t1 - w_t3;
  assign w_prodIm = w_t1 + w_t2;
`else
  assign w_prodRe = AW'(w_a) * AW'(w_c) - AW'(w_b) * AW'(w_d);
  assign w_prodIm = AW'(w_a) * AW'(w_d) + AW'(w_b) * AW'(w_c);
`endif

  assign w_sumRe  = r_accRe + w_prodRe;
  assign w_sumIm  = r_accIm + w_prodIm;
  assign w_accept = in_valid && (r_state == IDLE);

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state == COMPUTE);
  assign out_valid = (r_state == DONE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)            w_next = COMPUTE;
      COMPUTE: if (r_idx == 6'd63)      w_next = DONE;
      DONE:    if (out_ready)           w_next = IDLE;
      default:                          w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Operands are captured only on accept so later input changes cannot disturb a running product.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_aRe <= A_real;
      r_aIm <= A_imag;
      r_bRe <= B_real;
      r_bIm <= B_imag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_accRe <= '0;
      r_accIm <= '0;
      for (int m = 0; m < 4; m++) begin
        for (int n = 0; n < 4; n++) begin
          C_real[m][n] <= '0;
          C_imag[m][n] <= '0;
        end
      end
    end else if (w_accept) begin
      r_idx   <= '0;
      r_accRe <= '0;
      r_accIm <= '0;
    end else if (r_state == COMPUTE) begin
      r_idx <= r_idx + 6'd1;
      if (w_k == 2'd3) begin
        C_real[w_i][w_j] <= w_sumRe;
        C_imag[w_i][w_j] <= w_sumIm;
        r_accRe <= '0;
        r_accIm <= '0;
      end else begin
        r_accRe <= w_sumRe;
        r_accIm <= w_sumIm;
      end
    end
  end

endmodule

// File: tb/tb_matmul_4x4_complex_seq.sv
// Directed self-checking bench for matmul_4x4_complex_seq: latency, handshake, reset abort and streaming accepts.
module tb_matmul_4x4_complex_seq;
  localparam int W  = 4;
  localparam int CW = 2*W+3;

  typedef logic signed [W-1:0] mat_t [0:3][0:3];
  typedef int imat_t [0:3][0:3];

  logic clk = 1'b0;
  logic rst, in_valid, out_ready;
  logic in_ready, out_valid, busy;
  mat_t aR, aI, bR, bI;
  logic signed [CW-1:0] cR [0:3][0:3];
  logic signed [CW-1:0] cI [0:3][0:3];
  imat_t expR, expI;
  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  matmul_4x4_complex_seq #(.w(W)) dut (
    .clk(clk), .rst(rst),
    .A_real(aR), .A_imag(aI), .B_real(bR), .B_imag(bI),
    .in_valid(in_valid), .in_ready(in_ready),
    .C_real(cR), .C_imag(cI),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  task automatic checkOutput(input string tag, input logic signed [31:0] actual, input int expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Patterns: 0 identity A / ramp B, 1 all -8, 2 real A times imaginary B, 3 random
  task automatic applyStimulus(input int kind);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        case (kind)
          0: begin
            aR[r][c] = (r == c) ? W'(1) : W'(0);
            aI[r][c] = W'(0);
            bR[r][c] = W'(r*4 + c - 8);
            bI[r][c] = W'(-(r*4 + c - 8));
          end
          1: begin
            aR[r][c] = W'(-8); aI[r][c] = W'(-8);
            bR[r][c] = W'(-8); bI[r][c] = W'(-8);
          end
          2: begin
            aR[r][c] = W'(r + 1); aI[r][c] = W'(0);
            bR[r][c] = W'(0);     bI[r][c] = W'(r - 2);
          end
          default: begin
            aR[r][c] = W'($urandom_range(0, 15)); aI[r][c] = W'($urandom_range(0, 15));
            bR[r][c] = W'($urandom_range(0, 15)); bI[r][c] = W'($urandom_range(0, 15));
          end
        endcase
      end
    end
  endtask

  task automatic computeRef(input mat_t ar, input mat_t ai, input mat_t br, input mat_t bi);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        int sr = 0;
        int si = 0;
        for (int k = 0; k < 4; k++) begin
          sr += int'(ar[i][k]) * int'(br[k][j]) - int'(ai[i][k]) * int'(bi[k][j]);
          si += int'(ar[i][k]) * int'(bi[k][j]) + int'(ai[i][k]) * int'(br[k][j]);
        end
        expR[i][j] = sr;
        expI[i][j] = si;
      end
    end
  endtask

  task automatic checkMatrix(input string tag);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        checkOutput($sformatf("%s_re%0d%0d", tag, i, j), cR[i][j], expR[i][j]);
        checkOutput($sformatf("%s_im%0d%0d", tag, i, j), cI[i][j], expI[i][j]);
      end
    end
  endtask

  // Called just after a clock edge with the DUT idle; returns edges from accept to out_valid.
  task automatic runOp(output int lat);
    lat = -1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    applyStimulus(3);
    checkOutput("busy_after_accept", busy, 1);
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) checkOutput("out_valid_timeout", 0, 1);
  endtask

  task automatic releaseResult(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, "_in_ready_after_release"}, in_ready, 1);
    checkOutput({tag, "_out_valid_after_release"}, out_valid, 0);
  endtask

  initial begin : main
    int lat;
    int lastAccept;
    int accepts;
    int results;
    logic preReady;
    mat_t sAR, sAI, sBR, sBI;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    applyStimulus(0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_c_re00", cR[0][0], 0);
    checkOutput("reset_c_im33", cI[3][3], 0);

    // Identity A: result equals the stored B, including the wrapped -8 at (0,0)
    applyStimulus(0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        expR[r][c] = int'(bR[r][c]);
        expI[r][c] = int'(bI[r][c]);
      end
    runOp(lat);
    checkOutput("ident_latency", lat, 64);
    checkMatrix("ident");
    releaseResult("ident");

    // Most negative operands everywhere: largest accumulated magnitude
    applyStimulus(1);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        expR[r][c] = 0;
        expI[r][c] = 512;
      end
    runOp(lat);
    checkOutput("neg8_latency", lat, 64);
    checkMatrix("neg8");
    releaseResult("neg8");

    // Real A times imaginary B, then hold the result with out_ready low
    applyStimulus(2);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        expR[r][c] = 0;
        expI[r][c] = (r + 1) * -2;
      end
    runOp(lat);
    checkOutput("rimag_latency", lat, 64);
    checkMatrix("rimag");
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("hold%0d_out_valid", n), out_valid, 1);
      checkOutput($sformatf("hold%0d_in_ready", n), in_ready, 0);
      checkOutput($sformatf("hold%0d_c_im12", n), cI[1][2], -4);
      checkOutput($sformatf("hold%0d_c_re30", n), cR[3][0], 0);
    end
    releaseResult("rimag");

    // Abort mid-compute; in_valid left high to show reset wins
    applyStimulus(3);
    in_valid = 1'b1;
    @(posedge clk); #1;
    repeat (29) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_out_valid", out_valid, 0);
    checkOutput("abort_in_ready", in_ready, 1);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        checkOutput($sformatf("abort_re%0d%0d", r, c), cR[r][c], 0);
        checkOutput($sformatf("abort_im%0d%0d", r, c), cI[r][c], 0);
      end
    in_valid = 1'b0;

    applyStimulus(3);
    computeRef(aR, aI, bR, bI);
    runOp(lat);
    checkOutput("fresh_latency", lat, 64);
    checkMatrix("fresh");
    releaseResult("fresh");

    // Continuous in_valid with operands changing every cycle
    lastAccept = -1; accepts = 0; results = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 1; cyc <= 210; cyc++) begin
      applyStimulus(3);
      preReady = in_ready;
      if (preReady) begin
        sAR = aR; sAI = aI; sBR = bR; sBI = bI;
      end
      @(posedge clk); #1;
      if (preReady) begin
        if (lastAccept >= 0) checkOutput("stream_accept_interval", cyc - lastAccept, 66);
        lastAccept = cyc;
        accepts++;
        computeRef(sAR, sAI, sBR, sBI);
      end
      if (out_valid) begin
        results++;
        checkMatrix($sformatf("stream%0d", results));
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checkOutput("stream_accepts", accepts, 4);
    checkOutput("stream_results", results, 3);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
